// File: rtl/ex_stage_md_pkg.sv
// Shared definitions for the EX stage: opcodes, exception code, mul/div FSM
// state encoding and the field values of a pipeline bubble.
package ex_stage_md_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_XOR  = 4'd3,
    OP_ADDS = 4'd4,
    OP_ADDU = 4'd5,
    OP_SUBS = 4'd6,
    OP_SUBU = 4'd7,
    OP_SHRL = 4'd8,
    OP_SHLL = 4'd9,
    OP_MULU = 4'd10,
    OP_DIVU = 4'd11,
    OP_REMU = 4'd12
  } alu_op_e;

  localparam logic [2:0] EXP_OVERFLOW = 3'd4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic       BUB_EN       = 1'b0;
  localparam logic       BUB_GPR_WE_N = 1'b1;
  localparam logic [1:0] BUB_MEM_OP   = 2'd0;
  localparam logic [1:0] BUB_CTRL_OP  = 2'd0;
  localparam logic [2:0] BUB_EXP_CODE = 3'd0;

  function automatic logic is_md_op(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative multiply / divide unit: one result bit per cycle, DATA_W cycles.
//   state   | meaning
//   ST_IDLE | waiting for start; latches op and operands on start
//   ST_RUN  | iterating, down-counter r_cnt reaches 0 on the last step
//   ST_DONE | result valid, held until the pipeline accepts it (hold=0)
module md_unit
  import ex_stage_md_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_start,
  input  logic              i_hold,
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_in_0,
  input  logic [DATA_W-1:0] i_in_1,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_acc;  // product accumulator / partial remainder
  logic [DATA_W-1:0] r_x;    // shifted multiplicand / dividend->quotient
  logic [DATA_W-1:0] r_y;    // shifted multiplier / divisor

  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_shift;

  // Restoring division step; a zero divisor naturally yields all-ones
  // quotient and leaves the dividend in the remainder.
  assign w_trial = {r_acc, r_x[DATA_W-1]} - {1'b0, r_y};
  assign w_shift = {r_acc[DATA_W-2:0], r_x[DATA_W-1]};

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_acc   <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_op    <= i_op;
            r_acc   <= '0;
            r_x     <= i_in_0;
            r_y     <= i_in_1;
          end
        end
        ST_RUN: begin
          if (r_op == OP_MULU) begin
            if (r_y[0]) r_acc <= r_acc + r_x;
            r_x <= r_x << 1;
            r_y <= r_y >> 1;
          end else if (!w_trial[DATA_W]) begin
            r_acc <= w_trial[DATA_W-1:0];
            r_x   <= {r_x[DATA_W-2:0], 1'b1};
          end else begin
            r_acc <= w_shift;
            r_x   <= {r_x[DATA_W-2:0], 1'b0};
          end
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_DONE: begin
          if (!i_hold) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy   = ((r_state == ST_IDLE) && i_start) || (r_state == ST_RUN);
  assign o_done   = (r_state == ST_DONE);
  assign o_result = (r_op == OP_DIVU) ? r_x : r_acc;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU, iterative mul/div, and the EX/MEM register
// with flush/stall/bubble handling.
module ex_stage_md
  import ex_stage_md_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 30,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  int_detect,
  input  logic [ADDR_W-1:0]     id_pc,
  input  logic                  id_en,
  input  logic                  id_br_flag,
  input  logic [3:0]            id_alu_op,
  input  logic [DATA_W-1:0]     id_alu_in_0,
  input  logic [DATA_W-1:0]     id_alu_in_1,
  input  logic [1:0]            id_mem_op,
  input  logic [DATA_W-1:0]     id_mem_wr_data,
  input  logic [1:0]            id_ctrl_op,
  input  logic [REG_ADDR_W-1:0] id_dst_addr,
  input  logic                  id_gpr_we_,
  input  logic [2:0]            id_exp_code,
  output logic [ADDR_W-1:0]     ex_pc,
  output logic                  ex_en,
  output logic                  ex_br_flag,
  output logic [1:0]            ex_mem_op,
  output logic [DATA_W-1:0]     ex_mem_wr_data,
  output logic [1:0]            ex_ctrl_op,
  output logic [REG_ADDR_W-1:0] ex_dst_addr,
  output logic                  ex_gpr_we_,
  output logic [2:0]            ex_exp_code,
  output logic [DATA_W-1:0]     ex_out,
  output logic                  ex_busy
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] w_sum, w_diff, w_alu, w_md_result, w_result;
  logic [SH_W-1:0]   w_shamt;
  logic              w_ovf, w_md_op, w_md_done, w_squash, w_bubble;

  assign w_sum   = id_alu_in_0 + id_alu_in_1;
  assign w_diff  = id_alu_in_0 - id_alu_in_1;
  assign w_shamt = id_alu_in_1[SH_W-1:0];
  assign w_md_op = is_md_op(id_alu_op);

  always_comb begin
    w_alu = '0;
    w_ovf = 1'b0;
    case (id_alu_op)
      OP_AND:  w_alu = id_alu_in_0 & id_alu_in_1;
      OP_OR:   w_alu = id_alu_in_0 | id_alu_in_1;
      OP_XOR:  w_alu = id_alu_in_0 ^ id_alu_in_1;
      OP_ADDS: begin
        w_alu = w_sum;
        w_ovf = (id_alu_in_0[MSB] == id_alu_in_1[MSB]) && (w_sum[MSB] != id_alu_in_0[MSB]);
      end
      OP_ADDU: w_alu = w_sum;
      OP_SUBS: begin
        w_alu = w_diff;
        w_ovf = (id_alu_in_0[MSB] != id_alu_in_1[MSB]) && (w_diff[MSB] != id_alu_in_0[MSB]);
      end
      OP_SUBU: w_alu = w_diff;
      OP_SHRL: w_alu = id_alu_in_0 >> w_shamt;
      OP_SHLL: w_alu = id_alu_in_0 << w_shamt;
      default: w_alu = '0;
    endcase
  end

  md_unit #(.DATA_W(DATA_W)) u_md (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_squash),
    .i_start  (id_en & w_md_op),
    .i_hold   (stall),
    .i_op     (id_alu_op),
    .i_in_0   (id_alu_in_0),
    .i_in_1   (id_alu_in_1),
    .o_busy   (ex_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  assign w_result = w_md_op ? (w_md_done ? w_md_result : '0) : w_alu;
  assign w_squash = flush | int_detect;
  // Reset, squash, busy and invalid input all load the same bubble; stall
  // only wins over the latter two.
  assign w_bubble = reset | w_squash | (~stall & (ex_busy | ~id_en));

  always_ff @(posedge clk) begin
    if (w_bubble) begin
      ex_pc          <= '0;
      ex_en          <= BUB_EN;
      ex_br_flag     <= 1'b0;
      ex_mem_op      <= BUB_MEM_OP;
      ex_mem_wr_data <= '0;
      ex_ctrl_op     <= BUB_CTRL_OP;
      ex_dst_addr    <= '0;
      ex_gpr_we_     <= BUB_GPR_WE_N;
      ex_exp_code    <= BUB_EXP_CODE;
      ex_out         <= '0;
    end else if (!stall) begin
      ex_pc          <= id_pc;
      ex_en          <= 1'b1;
      ex_br_flag     <= id_br_flag;
      ex_mem_op      <= id_mem_op;
      ex_mem_wr_data <= id_mem_wr_data;
      ex_ctrl_op     <= id_ctrl_op;
      ex_dst_addr    <= id_dst_addr;
      ex_gpr_we_     <= w_ovf ? 1'b1 : id_gpr_we_;
      ex_exp_code    <= w_ovf ? EXP_OVERFLOW : id_exp_code;
      ex_out         <= w_result;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Scoreboard bench for ex_stage_md: expected results queued at stimulus time,
// popped and compared when the EX/MEM register presents them.
module tb_ex_stage_md;
  import ex_stage_md_pkg::*;

  localparam int DW = 32;
  localparam int AW = 30;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          reset, stall, flush, int_detect;
  logic [AW-1:0] id_pc;
  logic          id_en, id_br_flag;
  logic [3:0]    id_alu_op;
  logic [DW-1:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
  logic [1:0]    id_mem_op, id_ctrl_op;
  logic [RW-1:0] id_dst_addr;
  logic          id_gpr_we_;
  logic [2:0]    id_exp_code;
  logic [AW-1:0] ex_pc;
  logic          ex_en, ex_br_flag, ex_gpr_we_, ex_busy;
  logic [1:0]    ex_mem_op, ex_ctrl_op;
  logic [DW-1:0] ex_mem_wr_data, ex_out;
  logic [RW-1:0] ex_dst_addr;
  logic [2:0]    ex_exp_code;

  typedef struct packed {
    logic          en;
    logic [DW-1:0] out;
    logic [2:0]    code;
    logic          we_n;
    logic [1:0]    mop;
    logic [1:0]    cop;
  } res_t;

  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          en;
  } vec_t;

  localparam res_t BUBBLE = '{1'b0, 32'd0, 3'd0, 1'b1, 2'd0, 2'd0};

  res_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ex_stage_md dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .int_detect(int_detect),
    .id_pc(id_pc), .id_en(id_en), .id_br_flag(id_br_flag), .id_alu_op(id_alu_op),
    .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1), .id_mem_op(id_mem_op),
    .id_mem_wr_data(id_mem_wr_data), .id_ctrl_op(id_ctrl_op), .id_dst_addr(id_dst_addr),
    .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out), .ex_busy(ex_busy)
  );

  function automatic res_t observed();
    return '{ex_en, ex_out, ex_exp_code, ex_gpr_we_, ex_mem_op, ex_ctrl_op};
  endfunction

  function automatic res_t model(input logic [3:0] op, input logic [DW-1:0] a, b,
                                 input logic en);
    longint   s;
    logic [DW-1:0] v;
    logic     ovf;
    if (!en) return BUBBLE;
    v = '0;
    ovf = 1'b0;
    case (op)
      4'd1: v = a & b;
      4'd2: v = a | b;
      4'd3: v = a ^ b;
      4'd4: begin
        s = longint'($signed(a)) + longint'($signed(b));
        v = a + b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: v = a + b;
      4'd6: begin
        s = longint'($signed(a)) - longint'($signed(b));
        v = a - b;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd7: v = a - b;
      4'd8: v = a >> b[4:0];
      4'd9: v = a << b[4:0];
      4'd10: v = a * b;
      4'd11: v = (b == 0) ? '1 : a / b;
      4'd12: v = (b == 0) ? a : a % b;
      default: v = '0;
    endcase
    return '{1'b1, v, ovf ? 3'd4 : id_exp_code, ovf ? 1'b1 : id_gpr_we_, id_mem_op, id_ctrl_op};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] a, b, input logic en);
    id_alu_op = op; id_alu_in_0 = a; id_alu_in_1 = b; id_en = en;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    id_pc = 30'h155; id_br_flag = 1'b1;
    drive(4'd5, 32'd5, 32'd6, 1'b1);
    step(); step();
    n_vec++;
    if (observed() !== BUBBLE) begin
      n_err++; $display("FAIL reset_fields: got %h want %h", observed(), BUBBLE);
    end
    n_vec++;
    if ({ex_pc, ex_br_flag, ex_dst_addr, ex_mem_wr_data, ex_busy} !== '0) begin
      n_err++; $display("FAIL reset_misc: pc %h br %b dst %h wd %h busy %b want all 0",
                        ex_pc, ex_br_flag, ex_dst_addr, ex_mem_wr_data, ex_busy);
    end
    reset = 1'b0; id_br_flag = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_alu();
    vec_t vq[$];
    vec_t v;
    res_t e;
    logic [3:0] op;
    vq.push_back('{4'd5,  32'd10,        32'd20,        1'b1});
    vq.push_back('{4'd4,  32'h7FFFFFFF,  32'd1,         1'b1});
    vq.push_back('{4'd6,  32'h80000000,  32'd1,         1'b1});
    vq.push_back('{4'd6,  32'd5,         32'd3,         1'b1});
    vq.push_back('{4'd4,  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1});
    vq.push_back('{4'd1,  32'hF0F0_1234, 32'h0FF0_FF00, 1'b1});
    vq.push_back('{4'd2,  32'hF000_0001, 32'h0000_0F00, 1'b1});
    vq.push_back('{4'd3,  32'hAAAA_5555, 32'hFFFF_0000, 1'b1});
    vq.push_back('{4'd7,  32'd0,         32'd1,         1'b1});
    vq.push_back('{4'd8,  32'h80000000,  32'd36,        1'b1});
    vq.push_back('{4'd9,  32'd1,         32'd33,        1'b1});
    vq.push_back('{4'd0,  32'd7,         32'd9,         1'b1});
    vq.push_back('{4'd13, 32'd7,         32'd9,         1'b1});
    vq.push_back('{4'd15, 32'hFFFFFFFF,  32'd1,         1'b1});
    vq.push_back('{4'd5,  32'd1,         32'd2,         1'b0});
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 12));
      if (op > 4'd9) op = op + 4'd3;
      vq.push_back('{op, 32'($urandom), 32'($urandom), 1'b1});
    end
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      id_pc = 30'(i + 100); id_dst_addr = 5'(i); id_mem_wr_data = ~32'(i);
      drive(v.op, v.a, v.b, v.en);
      sb_q.push_back(model(v.op, v.a, v.b, v.en));
      step();
      e = sb_q.pop_front();
      n_vec++;
      if (observed() !== e) begin
        n_err++; $display("FAIL alu[%0d] op %0d: got %h want %h", i, v.op, observed(), e);
      end
      if (i == 0) begin
        n_vec++;
        if (ex_out !== 32'd30 || ex_en !== 1'b1 || ex_pc !== 30'd100 ||
            ex_dst_addr !== 5'd0 || ex_mem_wr_data !== 32'hFFFFFFFF) begin
          n_err++; $display("FAIL addu_passthru: out %0d en %b pc %h dst %h wd %h want 30 1 64 0 ffffffff",
                            ex_out, ex_en, ex_pc, ex_dst_addr, ex_mem_wr_data);
        end
      end
    end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_muldiv();
    vec_t vq[$];
    vec_t v;
    res_t e;
    int   edges, busy_cnt;
    logic bub_ok;
    vq.push_back('{4'd10, 32'd1234,      32'd5678,      1'b1});
    vq.push_back('{4'd11, 32'd100,       32'd7,         1'b1});
    vq.push_back('{4'd12, 32'd100,       32'd7,         1'b1});
    vq.push_back('{4'd11, 32'd5,         32'd0,         1'b1});
    vq.push_back('{4'd12, 32'd5,         32'd0,         1'b1});
    vq.push_back('{4'd10, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1});
    vq.push_back('{4'd11, 32'($urandom), 32'($urandom_range(1, 1000)), 1'b1});
    vq.push_back('{4'd12, 32'($urandom), 32'($urandom_range(1, 1000)), 1'b1});
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.op, v.a, v.b, 1'b1);
      sb_q.push_back(model(v.op, v.a, v.b, 1'b1));
      edges = 0; busy_cnt = 0; bub_ok = 1'b1;
      while (edges < 60) begin
        if (ex_busy === 1'b1) busy_cnt++;
        step();
        edges++;
        if (ex_en === 1'b1) break;
        if (ex_gpr_we_ !== 1'b1 || ex_mem_op !== 2'd0 || ex_out !== '0) bub_ok = 1'b0;
      end
      drive(4'd0, 32'd0, 32'd0, 1'b0);
      e = sb_q.pop_front();
      n_vec++;
      if (edges != DW + 2) begin
        n_err++; $display("FAIL md_latency[%0d]: got %0d edges want %0d", i, edges, DW + 2);
      end
      n_vec++;
      if (busy_cnt != DW + 1) begin
        n_err++; $display("FAIL md_busy[%0d]: got %0d cycles want %0d", i, busy_cnt, DW + 1);
      end
      n_vec++;
      if (observed() !== e) begin
        n_err++; $display("FAIL md_result[%0d] op %0d: got %h want %h", i, v.op, observed(), e);
      end
      n_vec++;
      if (!bub_ok) begin
        n_err++; $display("FAIL md_bubbles[%0d]: got non-bubble want bubble", i);
      end
    end
  endtask

  task automatic test_flush();
    res_t e;
    int   edges;
    flush = 1'b1;
    drive(4'd5, 32'd1, 32'd2, 1'b1);
    step();
    flush = 1'b0;
    n_vec++;
    if (observed() !== BUBBLE) begin
      n_err++; $display("FAIL flush_load: got %h want %h", observed(), BUBBLE);
    end
    drive(4'd10, 32'd7, 32'd9, 1'b1);
    repeat (10) step();
    flush = 1'b1; id_en = 1'b0;
    #1;
    step();
    flush = 1'b0;
    #1;
    n_vec++;
    if (observed() !== BUBBLE || ex_busy !== 1'b0) begin
      n_err++; $display("FAIL flush_run: got %h busy %b want %h busy 0", observed(), ex_busy, BUBBLE);
    end
    drive(4'd11, 32'd9, 32'd2, 1'b1);
    repeat (6) step();
    int_detect = 1'b1; id_en = 1'b0;
    #1;
    step();
    int_detect = 1'b0;
    #1;
    n_vec++;
    if (observed() !== BUBBLE || ex_busy !== 1'b0) begin
      n_err++; $display("FAIL int_run: got %h busy %b want %h busy 0", observed(), ex_busy, BUBBLE);
    end
    drive(4'd11, 32'd100, 32'd7, 1'b1);
    sb_q.push_back(model(4'd11, 32'd100, 32'd7, 1'b1));
    edges = 0;
    while (edges < 60) begin
      step();
      edges++;
      if (ex_en === 1'b1) break;
    end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    e = sb_q.pop_front();
    n_vec++;
    if (edges != DW + 2 || observed() !== e) begin
      n_err++; $display("FAIL restart_after_flush: got %0d edges %h want %0d edges %h",
                        edges, observed(), DW + 2, e);
    end
  endtask

  task automatic test_stall();
    res_t e, held;
    int   edges;
    drive(4'd5, 32'd3, 32'd4, 1'b1);
    sb_q.push_back(model(4'd5, 32'd3, 32'd4, 1'b1));
    held = model(4'd5, 32'd3, 32'd4, 1'b1);
    step();
    e = sb_q.pop_front();
    n_vec++;
    if (observed() !== e) begin
      n_err++; $display("FAIL stall_pre: got %h want %h", observed(), e);
    end
    stall = 1'b1;
    drive(4'd5, 32'd100, 32'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (observed() !== held) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, observed(), held);
      end
    end
    stall = 1'b0;
    drive(4'd10, 32'd3, 32'd5, 1'b1);
    sb_q.push_back(model(4'd10, 32'd3, 32'd5, 1'b1));
    repeat (DW + 1) step();
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (observed() !== BUBBLE || ex_busy !== 1'b0) begin
        n_err++; $display("FAIL done_stall[%0d]: got %h busy %b want %h busy 0",
                          i, observed(), ex_busy, BUBBLE);
      end
    end
    stall = 1'b0;
    #1;
    step();
    e = sb_q.pop_front();
    n_vec++;
    if (observed() !== e) begin
      n_err++; $display("FAIL done_release: got %h want %h", observed(), e);
    end
    drive(4'd10, 32'd6, 32'd7, 1'b1);
    sb_q.push_back(model(4'd10, 32'd6, 32'd7, 1'b1));
    edges = 0;
    while (edges < 60) begin
      stall = (edges >= 4 && edges < 9);
      #1;
      step();
      edges++;
      if (ex_en === 1'b1) break;
    end
    stall = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 1'b0);
    e = sb_q.pop_front();
    n_vec++;
    if (edges != DW + 2 || observed() !== e) begin
      n_err++; $display("FAIL run_stall: got %0d edges %h want %0d edges %h",
                        edges, observed(), DW + 2, e);
    end
  endtask

  task automatic test_reset_mid_run();
    res_t e;
    drive(4'd10, 32'd9, 32'd9, 1'b1);
    repeat (5) step();
    reset = 1'b1; id_en = 1'b0;
    #1;
    step();
    reset = 1'b0;
    #1;
    n_vec++;
    if (ex_busy !== 1'b0 || observed() !== BUBBLE) begin
      n_err++; $display("FAIL reset_mid_run: got %h busy %b want %h busy 0", observed(), ex_busy, BUBBLE);
    end
    drive(4'd5, 32'd2, 32'd2, 1'b1);
    sb_q.push_back(model(4'd5, 32'd2, 32'd2, 1'b1));
    step();
    e = sb_q.pop_front();
    n_vec++;
    if (observed() !== e) begin
      n_err++; $display("FAIL after_reset_addu: got %h want %h", observed(), e);
    end
    drive(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; int_detect = 1'b0;
    id_pc = '0; id_en = 1'b0; id_br_flag = 1'b0; id_alu_op = '0;
    id_alu_in_0 = '0; id_alu_in_1 = '0; id_mem_wr_data = '0;
    id_mem_op = 2'b11; id_ctrl_op = 2'b10; id_dst_addr = '0;
    id_gpr_we_ = 1'b0; id_exp_code = 3'd2;
    test_reset();
    test_alu();
    test_muldiv();
    test_flush();
    test_stall();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
